// File: rtl/bit_serial_adder.sv
// bit_serial_adder: WIDTH-bit unsigned add computed one bit per clock, LSB
// first, through a one-bit full-adder cell. A start/done handshake wraps the
// add. The result and carry-out are registered and hold between completions.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // One-hot encoding, so each state is a flop of its own.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    // One-bit full-adder cell. The result is returned as {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] s_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic             cell_sum_s;
    logic             cell_cout_s;
    logic [WIDTH-1:0] s_next_s;

    // Cell evaluation on the current LSBs, and the next partial-sum image.
    always_comb begin
        cell_sum_s  = 1'b0;
        cell_cout_s = 1'b0;
        {cell_cout_s, cell_sum_s} = full_add(a_sr_r[0], b_sr_r[0], carry_r);
        s_next_s = (s_sr_r >> 1'b1) | {cell_sum_s, {(WIDTH-1){1'b0}}};
    end

    // Control FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_sr_r  <= {WIDTH{1'b0}};
            b_sr_r  <= {WIDTH{1'b0}};
            s_sr_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= {WIDTH{1'b0}};
            cout    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
                        s_sr_r  <= {WIDTH{1'b0}};
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Operands shift out LSB first. Zeros fill the top bits.
                    s_sr_r  <= s_next_s;
                    a_sr_r  <= a_sr_r >> 1'b1;
                    b_sr_r  <= b_sr_r >> 1'b1;
                    carry_r <= cell_cout_s;
                    cnt_r   <= cnt_r + CW'(1'b1);
                    if (cnt_r == LAST_BIT) begin
                        sum     <= s_next_s;
                        cout    <= cell_cout_s;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Requests arriving here are dropped, not queued.
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder. A WIDTH=8 instance covers handshake,
// timing, ignored requests, async reset and back-to-back operation. A
// WIDTH=2 instance is swept exhaustively. Expected results come from a
// scoreboard queue.
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    logic [8:0]  sb8[$];
    logic [2:0]  sb2[$];
    logic [31:0] inj8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    bit_serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation. inj8[k] drives a 0xFF+0xFF request at the k-th
    // falling edge after the accepting edge.
    task automatic run_op8(input logic [7:0] aa, input logic [7:0] bb, input logic cc);
        int lat;
        int busy_n;
        int moved;
        logic [8:0] hold;
        logic [8:0] exp;
        @(negedge clk);
        a8 = aa; b8 = bb; cin8 = cc; start8 = 1'b1;
        sb8.push_back(9'(aa) + 9'(bb) + 9'(cc));
        @(negedge clk);
        hold   = {cout8, sum8};
        busy_n = 32'(busy8);
        lat    = 0;
        moved  = 0;
        for (int k = 1; k <= 20; k++) begin
            start8 = inj8[k];
            if (inj8[k]) begin
                a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
            @(negedge clk);
            busy_n += 32'(busy8);
            if (done8) begin
                lat = k;
                break;
            end
            if ({cout8, sum8} !== hold) moved++;
        end
        check("latency8", 32'(lat), 32'd8);
        check("busy_cycles8", 32'(busy_n), 32'd9);
        check("sum_stable8", 32'(moved), 32'd0);
        exp = (sb8.size() > 0) ? sb8.pop_front() : 9'h1FF;
        check("result8", 32'({cout8, sum8}), 32'(exp));
        start8 = inj8[lat + 1];
        if (inj8[lat + 1]) begin
            a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        end else begin
            a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        end
        @(negedge clk);
        start8 = 1'b0;
        check("done_width8", 32'(done8), 32'd0);
        check("busy_fall8", 32'(busy8), 32'd0);
    endtask

    // One WIDTH=2 operation with latency and result check.
    task automatic run_op2(input logic [1:0] aa, input logic [1:0] bb, input logic cc);
        int lat;
        logic [2:0] exp;
        @(negedge clk);
        a2 = aa; b2 = bb; cin2 = cc; start2 = 1'b1;
        sb2.push_back(3'(aa) + 3'(bb) + 3'(cc));
        @(negedge clk);
        start2 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done2) begin
                lat = k;
                break;
            end
        end
        check("latency2", 32'(lat), 32'd2);
        exp = (sb2.size() > 0) ? sb2.pop_front() : 3'h7;
        check("result2", 32'({cout2, sum2}), 32'(exp));
    endtask

    initial begin
        int extra;
        logic [8:0] exp;
        rst = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0;
        inj8 = 32'h0;
        #12;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_result", 32'({cout8, sum8}), 32'd0);
        check("rst_result2", 32'({busy2, done2, cout2, sum2}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic adds, including full carry ripple.
        run_op8(8'h5A, 8'h3C, 1'b0);
        run_op8(8'hFF, 8'h01, 1'b0);
        run_op8(8'hFF, 8'hFF, 1'b1);

        // Requests during RUN and DONE are ignored.
        inj8 = (32'h1 << 3) | (32'h1 << 9);
        run_op8(8'h12, 8'h34, 1'b0);
        inj8 = 32'h0;
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        check("no_extra_op", 32'(extra), 32'd0);
        check("held_result", 32'({cout8, sum8}), 32'h046);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        a8 = 8'hC3; b8 = 8'h7E; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy8), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy8), 32'd0);
        check("async_rst_result", 32'({done8, cout8, sum8}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        check("no_done_after_abort", 32'(extra), 32'd0);
        run_op8(8'h01, 8'h01, 1'b0);

        // start held high: an accept every 10 edges, with operands changing
        // every cycle.
        for (int j = 0; j <= 40; j++) begin
            if (j > 0) begin
                check("hold_done_cadence", 32'(done8), 32'((j % 10) == 9));
                if (done8) begin
                    exp = (sb8.size() > 0) ? sb8.pop_front() : 9'h1FF;
                    check("hold_result", 32'({cout8, sum8}), 32'(exp));
                end
            end
            if (j < 40) begin
                start8 = 1'b1;
                a8 = 8'(j * 37 + 5);
                b8 = 8'(j * 91 + 13);
                cin8 = 1'(j);
                if ((j % 10) == 0) sb8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
                @(negedge clk);
            end else begin
                start8 = 1'b0;
            end
        end
        check("hold_queue_empty", 32'(sb8.size()), 32'd0);

        // Exhaustive WIDTH=2 sweep.
        for (int v = 0; v < 32; v++) begin
            run_op2(2'(v), 2'(v >> 2), 1'(v >> 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
